square_drawer: RTL and testbench
================================

# square_drawer

Pixel-drawing datapath that answers the game controller's draw/plot request and returns `finish_drawing`. On each accepted request it erases the square drawn last frame in the background colour. It then draws a SIZE×SIZE square at a newly latched position and colour, emitting one pixel per cycle to the 160×120 VGA frame-buffer adapter. It sits between the game controller and the VGA adapter.

## Interface
- `SIZE`, 4 — square edge in pixels; power of two, 2..16
- `SCREEN_W`, 160 — visible width; pixels at x ≥ SCREEN_W are clipped
- `SCREEN_H`, 120 — visible height; pixels at y ≥ SCREEN_H are clipped
- `BG_COLOUR`, 3'b000 — erase colour

Ports:
- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-low
- `draw`  in  1  request; sampled only in IDLE
- `new_x`  in  8  top-left x of the new square
- `new_y`  in  7  top-left y of the new square
- `new_colour`  in  3  colour of the new square
- `busy`  out  1  high in every state except IDLE
- `x`  out  8  pixel x to adapter
- `y`  out  7  pixel y to adapter
- `colour`  out  3  pixel colour to adapter
- `plot`  out  1  adapter write enable
- `finish_drawing`  out  1  one-cycle completion pulse

## Operation
- States:
  - IDLE: wait for a request.
  - ERASE: clear the previous square.
  - PAINT: draw the new square.
  - DONE: signal completion.
- IDLE & `draw`:
  - Latch `new_x`/`new_y`/`new_colour` into `cur_*`.
  - Clear the pixel counter `k` (width 2·log2(SIZE)).
  - Go to ERASE if `old_valid`, else go to PAINT.
- ERASE:
  - Pixel k is at x = old_x + k mod SIZE, y = old_y + k / SIZE, colour = BG_COLOUR.
  - After k = SIZE²−1: clear k, go to PAINT.
- PAINT:
  - Pixel k is at x = cur_x + k mod SIZE, y = cur_y + k / SIZE, colour = cur_colour.
  - After k = SIZE²−1: go to DONE.
- DONE:
  - `finish_drawing` = 1.
  - Copy `cur_*` into `old_*` and set `old_valid`.
  - Go to IDLE.
- Address arithmetic:
  - Computed at 9 bits for x and 8 bits for y.
  - When the sum is ≥ SCREEN_W or ≥ SCREEN_H, `plot` = 0 for that pixel but k still advances. There is no wrap-around onto the opposite edge.
  - `x`/`y` outputs carry the low 8/7 bits.
- `draw` in any state other than IDLE is ignored; the request is not queued.
- The `new_*` inputs are don't-care except in the cycle a request is accepted.
- `plot` = 1 only in ERASE/PAINT for unclipped pixels. `x`/`y`/`colour` hold their last value elsewhere.

## Timing
- Reset values:
  - All outputs are 0.
  - State = IDLE, `old_valid` = 0, k = 0, `cur_*` and `old_*` = 0.
- Reset mid-operation aborts on the next edge. No further `plot` or `finish_drawing` follows, and the next request skips ERASE.
- Accepted `draw` at edge N: pixel 0 is driven in cycle N+1.
- One pixel per cycle, no stalls.
- Latency from acceptance to `finish_drawing`:
  - 2·SIZE² + 1 cycles with erase.
  - SIZE² + 1 cycles without erase.
  - With SIZE = 4: 33 or 17 cycles.
- `busy` is high from N+1 through the DONE cycle inclusive. A new request is accepted at the first edge after DONE at the earliest.
- Pixel outputs and `plot` are combinational from the state/k/address registers and are valid for the whole cycle.

## Configuration
- Macro `SQUARE_DRAWER_ERASE_EN`.
- Defined: behaviour as above, with the ERASE pass used whenever `old_valid` = 1.
- Undefined:
  - ERASE is never entered; acceptance always goes straight to PAINT.
  - `old_*`/`old_valid` are not implemented.
  - Latency is always SIZE² + 1.
  - `BG_COLOUR` is unused.

## Test plan
- After reset, `draw` with (10,20,3'b100) and SIZE = 4:
  - 16 `plot` pulses covering x 10..13 and y 20..23, row-major, colour 4.
  - `finish_drawing` at cycle 17, `busy` low at cycle 18.
- Second `draw` with (11,20,3'b010), ERASE_EN defined:
  - 16 pixels at (10..13, 20..23) in colour 0, then 16 pixels at (11..14, 20..23) in colour 2.
  - `finish_drawing` at cycle 33.
- `draw` with (158,118,1):
  - Only (158,118), (159,118), (158,119) and (159,119) are plotted; the other 12 cycles have `plot` = 0.
  - `finish_drawing` still arrives at cycle 17.
- `draw` held high through the whole operation:
  - Exactly one operation per IDLE visit.
  - Next acceptance in the cycle after the DONE cycle, i.e. back-to-back operations separated by one IDLE cycle.
- `reset` asserted at pixel 5 of PAINT:
  - All outputs 0 on the next cycle and no `finish_drawing`.
  - The following `draw` performs no erase: 16 pixels, `finish_drawing` at cycle 17.
- ERASE_EN undefined, two successive `draw` requests:
  - Each produces 16 pixels and `finish_drawing` at cycle 17.
  - No pixel is ever plotted in colour 0 unless requested.

Source files
------------

// File: rtl/square_drawer.sv
// Erases the previously drawn square, then paints a new SIZE x SIZE square one pixel per cycle.
// The erase pass is built only when SQUARE_DRAWER_ERASE_EN is defined; by default it is left out.
module square_drawer #(
    parameter int unsigned SIZE      = 4,
    parameter int unsigned SCREEN_W  = 160,
    parameter int unsigned SCREEN_H  = 120,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       draw,
    input  logic [7:0] new_x,
    input  logic [6:0] new_y,
    input  logic [2:0] new_colour,
    output logic       busy,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       finish_drawing
);

    localparam int unsigned LOG2 = $clog2(SIZE);
    localparam int unsigned KW   = 2 * LOG2;
    localparam logic [KW-1:0] K_LAST = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        PAINT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [7:0]      cur_x_q, cur_x_d;
    logic [6:0]      cur_y_q, cur_y_d;
    logic [2:0]      cur_col_q, cur_col_d;
    logic [7:0]      last_x_q, last_x_d;
    logic [6:0]      last_y_q, last_y_d;
    logic [2:0]      last_col_q, last_col_d;
`ifdef SQUARE_DRAWER_ERASE_EN
    logic [7:0]      old_x_q, old_x_d;
    logic [6:0]      old_y_q, old_y_d;
    logic            old_valid_q, old_valid_d;
`endif

    logic [7:0]      base_x_c;
    logic [6:0]      base_y_c;
    logic [2:0]      pix_col_c;
    logic [8:0]      sum_x_c;
    logic [7:0]      sum_y_c;
    logic            active_c;
    logic            visible_c;

    // Pixel address for counter k: low bits step along the row, high bits select the row.
    always_comb begin
        base_x_c  = cur_x_q;
        base_y_c  = cur_y_q;
        pix_col_c = cur_col_q;
        if (state_q == ERASE) begin
`ifdef SQUARE_DRAWER_ERASE_EN
            base_x_c = old_x_q;
            base_y_c = old_y_q;
`endif
            pix_col_c = BG_COLOUR;
        end
        sum_x_c   = 9'(base_x_c) + 9'(k_q[LOG2-1:0]);
        sum_y_c   = 8'(base_y_c) + 8'(k_q[KW-1:LOG2]);
        active_c  = (state_q == ERASE) || (state_q == PAINT);
        visible_c = (sum_x_c < 9'(SCREEN_W)) && (sum_y_c < 8'(SCREEN_H));
    end

    // Adapter-facing outputs; pixel fields hold their last value outside the drawing passes.
    always_comb begin
        busy           = (state_q != IDLE);
        finish_drawing = (state_q == DONE);
        plot           = active_c && visible_c;
        x              = active_c ? sum_x_c[7:0] : last_x_q;
        y              = active_c ? sum_y_c[6:0] : last_y_q;
        colour         = active_c ? pix_col_c    : last_col_q;
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        cur_col_d  = cur_col_q;
        last_x_d   = last_x_q;
        last_y_d   = last_y_q;
        last_col_d = last_col_q;
`ifdef SQUARE_DRAWER_ERASE_EN
        old_x_d     = old_x_q;
        old_y_d     = old_y_q;
        old_valid_d = old_valid_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (draw) begin
                    cur_x_d   = new_x;
                    cur_y_d   = new_y;
                    cur_col_d = new_colour;
                    k_d       = '0;
`ifdef SQUARE_DRAWER_ERASE_EN
                    state_d   = old_valid_q ? ERASE : PAINT;
`else
                    state_d   = PAINT;
`endif
                end
            end
            ERASE: begin
                k_d = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = PAINT;
                end
            end
            PAINT: begin
                k_d = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
`ifdef SQUARE_DRAWER_ERASE_EN
                old_x_d     = cur_x_q;
                old_y_d     = cur_y_q;
                old_valid_d = 1'b1;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (active_c) begin
            last_x_d   = sum_x_c[7:0];
            last_y_d   = sum_y_c[6:0];
            last_col_d = pix_col_c;
        end
    end

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            k_q        <= '0;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            cur_col_q  <= '0;
            last_x_q   <= '0;
            last_y_q   <= '0;
            last_col_q <= '0;
`ifdef SQUARE_DRAWER_ERASE_EN
            old_x_q     <= '0;
            old_y_q     <= '0;
            old_valid_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            cur_col_q  <= cur_col_d;
            last_x_q   <= last_x_d;
            last_y_q   <= last_y_d;
            last_col_q <= last_col_d;
`ifdef SQUARE_DRAWER_ERASE_EN
            old_x_q     <= old_x_d;
            old_y_q     <= old_y_d;
            old_valid_q <= old_valid_d;
`endif
        end
    end

endmodule

// File: tb/tb_square_drawer.sv
// Directed bench for square_drawer: pixel sequence, clipping, held request, mid-operation reset.
`timescale 1ns/1ps
module tb_square_drawer;

`ifdef SQUARE_DRAWER_ERASE_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       draw  = 1'b0;
    logic [7:0] new_x = '0;
    logic [6:0] new_y = '0;
    logic [2:0] new_colour = '0;
    logic       busy;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       finish_drawing;

    int n_checks = 0;
    int n_fail   = 0;
    int plots;

    square_drawer dut (
        .clock          (clock),
        .reset          (reset),
        .draw           (draw),
        .new_x          (new_x),
        .new_y          (new_y),
        .new_colour     (new_colour),
        .busy           (busy),
        .x              (x),
        .y              (y),
        .colour         (colour),
        .plot           (plot),
        .finish_drawing (finish_drawing)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Starts at a negedge in IDLE; ends at the negedge of the IDLE cycle after DONE.
    task automatic run_op(input logic [7:0] nx, input logic [6:0] ny, input logic [2:0] nc,
                          input bit do_erase, input logic [7:0] ox, input logic [6:0] oy,
                          input bit hold, output int n_plots);
        int total;
        int p;
        int exp_plots;
        logic [8:0] ex;
        logic [7:0] ey;
        logic [2:0] ec;
        bit vis;
        total     = do_erase ? 33 : 17;
        n_plots   = 0;
        exp_plots = 0;
        check("idle_busy", 32'(busy), 32'd0);
        draw = 1'b1; new_x = nx; new_y = ny; new_colour = nc;
        @(posedge clock);
        #1;
        if (!hold) draw = 1'b0;
        new_x = 8'hA5; new_y = 7'h5A; new_colour = 3'b111;
        for (int c = 1; c <= total; c++) begin
            @(negedge clock);
            if (c == total) begin
                check("done_finish", 32'(finish_drawing), 32'd1);
                check("done_busy",   32'(busy), 32'd1);
                check("done_plot",   32'(plot), 32'd0);
            end else begin
                if (do_erase && c <= 16) begin
                    p  = c - 1;
                    ex = 9'(ox) + 9'(p % 4);
                    ey = 8'(oy) + 8'(p / 4);
                    ec = 3'b000;
                end else begin
                    p  = c - 1 - (do_erase ? 16 : 0);
                    ex = 9'(nx) + 9'(p % 4);
                    ey = 8'(ny) + 8'(p / 4);
                    ec = nc;
                end
                vis = (ex < 9'd160) && (ey < 8'd120);
                check("pix_plot", 32'(plot), 32'(vis));
                if (vis) check("pix_xyc", 32'({x, y, colour}), 32'({ex[7:0], ey[6:0], ec}));
                check("pix_busy_fin", 32'({busy, finish_drawing}), 32'b10);
                n_plots   += 32'(plot);
                exp_plots += 32'(vis);
            end
        end
        @(negedge clock);
        check("idle_after", 32'({busy, finish_drawing, plot}), 32'd0);
        check("plot_count", 32'(n_plots), 32'(exp_plots));
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("reset_outs", 32'({busy, x, y, colour, plot, finish_drawing}), 32'd0);
        reset = 1'b1;

        run_op(8'd10, 7'd20, 3'b100, 1'b0, 8'd0, 7'd0, 1'b0, plots);
        check("op1_count", 32'(plots), 32'd16);

        run_op(8'd11, 7'd20, 3'b010, EN, 8'd10, 7'd20, 1'b0, plots);
        check("op2_count", 32'(plots), EN ? 32'd32 : 32'd16);

        run_op(8'd158, 7'd118, 3'b001, EN, 8'd11, 7'd20, 1'b0, plots);
        check("clip_count", 32'(plots), EN ? 32'd20 : 32'd4);

        run_op(8'd30, 7'd40, 3'b101, EN, 8'd158, 7'd118, 1'b1, plots);
        check("held1_count", 32'(plots), EN ? 32'd20 : 32'd16);
        run_op(8'd30, 7'd40, 3'b101, EN, 8'd30, 7'd40, 1'b0, plots);
        check("held2_count", 32'(plots), EN ? 32'd32 : 32'd16);

        check("abort_idle0", 32'(busy), 32'd0);
        draw = 1'b1; new_x = 8'd50; new_y = 7'd60; new_colour = 3'b110;
        @(posedge clock);
        #1 draw = 1'b0;
        repeat ((EN ? 16 : 0) + 6) @(negedge clock);
        check("abort_pix5", 32'({plot, x, y, colour}), 32'({1'b1, 8'd51, 7'd61, 3'b110}));
        reset = 1'b0;
        @(negedge clock);
        check("abort_zero", 32'({busy, x, y, colour, plot, finish_drawing}), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check("abort_idle", 32'({busy, finish_drawing, plot}), 32'd0);

        run_op(8'd70, 7'd80, 3'b111, 1'b0, 8'd0, 7'd0, 1'b0, plots);
        check("post_abort_count", 32'(plots), 32'd16);

        run_op(8'd90, 7'd100, 3'b011, EN, 8'd70, 7'd80, 1'b0, plots);
        check("last_count", 32'(plots), EN ? 32'd32 : 32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
